// File: rtl/mult_issue_if.sv
// Operand request, product response and multu-side signals of mult_issue_ctrl.
// slave = the controller; master = the issuing datapath / multu environment.
interface mult_issue_if #(
   parameter int WIDTH = 32
);
   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic [WIDTH-1:0] mul_a;
   logic [WIDTH-1:0] mul_b;
   logic             mul_reset;
   logic             mul_do;
   logic [WIDTH-1:0] mul_out;
   logic             mul_done;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_err;
   logic             busy;

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready, mul_out, mul_done,
      output req_ready, rsp_valid, rsp_data, rsp_err, busy, mul_a, mul_b, mul_reset, mul_do
   );

   modport master (
      output req_valid, req_a, req_b, rsp_ready, mul_out, mul_done,
      input  req_ready, rsp_valid, rsp_data, rsp_err, busy, mul_a, mul_b, mul_reset, mul_do
   );
endinterface

// File: rtl/mult_issue_ctrl.sv
// Issue controller for multu: one op in flight, CLEAR/START/WAIT sequencing, product held until taken.
// Latency: accept c0, CLEAR c1, START c2, WAIT from c3, rsp_valid the cycle after mul_done seen in WAIT.
// Backpressure: req_ready only in IDLE; rsp held until rsp_ready. MULT_TIMEOUT_EN adds the WAIT abort.
module mult_issue_ctrl #(
   parameter int WIDTH          = 32,
   parameter int TIMEOUT_CYCLES = 96
) (
   input  logic        clk,
   input  logic        reset,
   mult_issue_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_START,
      S_WAIT,
      S_RESP
   } state_t;

   state_t           state_q;
   logic             req_ready_q;
   logic             mul_reset_q;
   logic             mul_do_q;
   logic             rsp_valid_q;
   logic             busy_q;
   logic [WIDTH-1:0] mul_a_q;
   logic [WIDTH-1:0] mul_b_q;
   logic [WIDTH-1:0] rsp_data_q;

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("mult_issue_ctrl: TIMEOUT_CYCLES must be at least 2");
   end

`ifdef MULT_TIMEOUT_EN
   localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             rsp_err_q;

   always_comb begin
      cnt_d = cnt_q;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
   end

   assign bus.rsp_err = rsp_err_q;
`else
   assign bus.rsp_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         req_ready_q <= 1'b1;
         mul_reset_q <= 1'b1;
         mul_do_q    <= 1'b0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         busy_q      <= 1'b0;
`ifdef MULT_TIMEOUT_EN
         rsp_err_q   <= 1'b0;
         cnt_q       <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.req_valid && req_ready_q) begin
                  mul_a_q     <= bus.req_a;
                  mul_b_q     <= bus.req_b;
                  req_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  mul_reset_q <= 1'b1;
                  state_q     <= S_CLEAR;
               end else begin
                  mul_reset_q <= 1'b0;
               end
            end
            // multu's done/out may still carry the previous op; the clear cycle flushes them.
            S_CLEAR: begin
               mul_reset_q <= 1'b0;
               mul_do_q    <= 1'b1;
               state_q     <= S_START;
            end
            S_START: begin
               mul_do_q <= 1'b0;
               state_q  <= S_WAIT;
`ifdef MULT_TIMEOUT_EN
               cnt_q    <= '0;
`endif
            end
            S_WAIT: begin
               if (bus.mul_done) begin
                  rsp_data_q  <= bus.mul_out;
                  rsp_valid_q <= 1'b1;
                  state_q     <= S_RESP;
`ifdef MULT_TIMEOUT_EN
                  rsp_err_q   <= 1'b0;
               end else if (cnt_q == CNT_LAST) begin
                  rsp_data_q  <= '0;
                  rsp_err_q   <= 1'b1;
                  rsp_valid_q <= 1'b1;
                  state_q     <= S_RESP;
               end else begin
                  cnt_q <= cnt_d;
`endif
               end
            end
            S_RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               req_ready_q <= 1'b1;
               mul_do_q    <= 1'b0;
               rsp_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.mul_a     = mul_a_q;
   assign bus.mul_b     = mul_b_q;
   assign bus.mul_reset = mul_reset_q;
   assign bus.mul_do    = mul_do_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Bench for mult_issue_ctrl: behavioural multu, timeline reference model, directed and random traffic.
module tb_mult_issue_ctrl;

   localparam int TO = 96;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mult_issue_if #(.WIDTH(32)) bus ();

   mult_issue_ctrl #(.WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int do_cnt = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at t=%0t: got %h, expected %h", nm, $time, got, exp);
      end
   endtask

   // behavioural multu: done mdl_lat cycles after the doMult cycle, held until its reset
   int          mdl_lat     = 1;
   bit          mdl_never   = 1'b0;
   bit          stale_en    = 1'b0;
   bit          inject_done = 1'b0;
   logic        m_run       = 1'b0;
   logic        m_done      = 1'b0;
   int          m_rem       = 0;
   logic [31:0] m_prod      = '0;

   always @(posedge clk) begin
      if (bus.mul_reset === 1'b1) begin
         m_run  <= 1'b0;
         m_done <= 1'b0;
         m_rem  <= 0;
      end else if (bus.mul_do === 1'b1) begin
         m_prod <= bus.mul_a * bus.mul_b;
         if (mdl_lat <= 1) m_done <= !mdl_never;
         else begin
            m_run <= 1'b1;
            m_rem <= mdl_lat - 1;
         end
      end else if (m_run) begin
         if (m_rem == 1) begin
            m_run  <= 1'b0;
            m_done <= !mdl_never;
         end
         m_rem <= m_rem - 1;
      end
   end

   assign bus.mul_done = m_done | inject_done | (stale_en & !m_run & !m_done);
   assign bus.mul_out  = m_done ? m_prod : 32'hDEADBEEF;

   // reference: each op is a timeline relative to its accept cycle
   int          cyc      = 0;
   bit          started  = 1'b0;
   bit          just_rst = 1'b0;
   bit          act      = 1'b0;
   int          t_acc    = 0;
   int          t_done   = -1;
   logic [31:0] ea, eb, ed;
   logic        ee;

   always @(negedge clk) begin
      int   k;
      logic x_valid;
      k       = cyc - t_acc;
      x_valid = act && (t_done >= 0) && (cyc > t_done);
      if (started) begin
         chk("busy",      bus.busy,      act);
         chk("req_ready", bus.req_ready, !act);
         chk("rsp_valid", bus.rsp_valid, x_valid);
         chk("mul_reset", bus.mul_reset, just_rst || (act && k == 1));
         chk("mul_do",    bus.mul_do,    act && k == 2);
         if (act) begin
            chk("mul_a", bus.mul_a, ea);
            chk("mul_b", bus.mul_b, eb);
         end
         if (just_rst) begin
            chk("rst_mul_a",    bus.mul_a,    0);
            chk("rst_mul_b",    bus.mul_b,    0);
            chk("rst_rsp_data", bus.rsp_data, 0);
            chk("rst_rsp_err",  bus.rsp_err,  0);
         end
         if (x_valid) begin
            chk("rsp_data", bus.rsp_data, ed);
            chk("rsp_err",  bus.rsp_err,  ee);
         end
`ifndef MULT_TIMEOUT_EN
         chk("rsp_err_tied", bus.rsp_err, 0);
`endif
      end
      if (bus.mul_do === 1'b1) do_cnt++;
      if (!reset) begin
         started  = 1'b1;
         just_rst = 1'b1;
         act      = 1'b0;
      end else begin
         just_rst = 1'b0;
         if (started) begin
            if (!act) begin
               if (bus.req_valid) begin
                  act    = 1'b1;
                  t_acc  = cyc;
                  t_done = -1;
                  ea     = bus.req_a;
                  eb     = bus.req_b;
               end
            end else if (t_done < 0) begin
               if (k >= 3) begin
                  if (bus.mul_done === 1'b1) begin
                     t_done = cyc;
                     ed     = ea * eb;
                     ee     = 1'b0;
                  end
`ifdef MULT_TIMEOUT_EN
                  else if (k - 3 == TO - 1) begin
                     t_done = cyc;
                     ed     = '0;
                     ee     = 1'b1;
                  end
`endif
               end
            end else if (bus.rsp_ready) begin
               act = 1'b0;
            end
         end
      end
      cyc++;
   end

   task automatic issue(input logic [31:0] a, input logic [31:0] b);
      int n = 0;
      @(posedge clk); #1;
      bus.req_valid = 1'b1;
      bus.req_a     = a;
      bus.req_b     = b;
      @(negedge clk);
      while (bus.req_ready !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("accept_in_time", n < 300, 1);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
   endtask

   // returns the cycle index (accept = 0) at which rsp_valid is first seen, or max
   task automatic wait_rsp(input int max, output int n);
      n = 0;
      while (n < max) begin
         @(negedge clk);
         n++;
         if (bus.rsp_valid === 1'b1) break;
      end
   endtask

   task automatic finish_rsp(input int hold, input logic [31:0] exp);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         bus.req_valid = i[0];
         bus.req_a     = $urandom;
         @(negedge clk);
         chk("hold_valid", bus.rsp_valid, 1);
         chk("hold_data",  bus.rsp_data,  exp);
         chk("hold_ready", bus.req_ready, 0);
      end
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h0000_0001;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      int n;
      reset         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("t0_req_ready", bus.req_ready, 1);
      chk("t0_mul_reset", bus.mul_reset, 1);
      chk("t0_busy",      bus.busy,      0);
      chk("t0_rsp_valid", bus.rsp_valid, 0);

      // 2 x 5, minimum latency
      d0      = do_cnt;
      mdl_lat = 1;
      issue(32'd2, 32'd5);
      wait_rsp(300, n);
      chk("t1_rsp_cycle", n, 4);
      chk("t1_data", bus.rsp_data, 32'h0000_000A);
      chk("t1_err",  bus.rsp_err,  0);
      finish_rsp(0, 32'h0000_000A);
      chk("t1_mul_do_pulses", do_cnt - d0, 1);

      // held response under backpressure
      mdl_lat = 4;
      issue(32'h03, 32'h69);
      wait_rsp(300, n);
      chk("t2_rsp_cycle", n, 7);
      chk("t2_data", bus.rsp_data, 32'h0000_013B);
      finish_rsp(5, 32'h0000_013B);

      // truncated products
      mdl_lat = 2;
      issue(32'hFFFF_FFFF, 32'h2);
      wait_rsp(300, n);
      chk("t3a_data", bus.rsp_data, 32'hFFFF_FFFE);
      finish_rsp(1, 32'hFFFF_FFFE);
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_rsp(300, n);
      chk("t3b_data", bus.rsp_data, 32'h0000_0001);
      finish_rsp(0, 32'h0000_0001);

      // stale done during CLEAR/START must be ignored
      stale_en = 1'b1;
      mdl_lat  = 3;
      issue(32'd7, 32'd9);
      wait_rsp(300, n);
      chk("t4_rsp_cycle", n, 6);
      chk("t4_data", bus.rsp_data, 32'h0000_003F);
      finish_rsp(0, 32'h0000_003F);
      stale_en = 1'b0;

      // reset mid-WAIT, then a late done
      mdl_lat = 20;
      issue(32'd11, 32'd13);
      repeat (5) @(negedge clk);
      @(posedge clk); #1 reset = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      chk("t5_busy",      bus.busy,      0);
      chk("t5_rsp_valid", bus.rsp_valid, 0);
      chk("t5_mul_reset", bus.mul_reset, 1);
      chk("t5_req_ready", bus.req_ready, 1);
      @(posedge clk); #1 inject_done = 1'b1;
      repeat (3) @(posedge clk);
      #1 inject_done = 1'b0;
      wait_rsp(25, n);
      chk("t5_no_late_rsp", bus.rsp_valid, 0);
      mdl_lat = 2;
      issue(32'd6, 32'd7);
      wait_rsp(300, n);
      chk("t5_next_data", bus.rsp_data, 32'h0000_002A);
      finish_rsp(0, 32'h0000_002A);

      // multu never finishes
      mdl_never = 1'b1;
      issue(32'd3, 32'd4);
`ifdef MULT_TIMEOUT_EN
      wait_rsp(300, n);
      chk("t6_rsp_cycle", n, 99);
      chk("t6_err",  bus.rsp_err,  1);
      chk("t6_data", bus.rsp_data, 0);
      finish_rsp(0, 32'h0);
`else
      wait_rsp(2 * TO + 8, n);
      chk("t6_no_rsp", bus.rsp_valid, 0);
      chk("t6_busy",   bus.busy,      1);
      @(posedge clk); #1 reset = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
`endif
      mdl_never = 1'b0;

      // random traffic against the reference
      for (int c = 0; c < 2000; c++) begin
         @(posedge clk); #1;
         bus.req_valid = ($urandom_range(0, 2) == 0);
         bus.req_a     = pick();
         bus.req_b     = pick();
         bus.rsp_ready = $urandom_range(0, 1) == 1;
         mdl_lat       = $urandom_range(1, 6);
         stale_en      = ($urandom_range(0, 7) == 0);
      end
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      stale_en      = 1'b0;
      repeat (30) @(posedge clk);
      @(negedge clk);
      chk("end_idle", bus.busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
